// File: rtl/bit_serializer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bit_ser_pkg
// Shared constants and types for the bit serializer controller.
//   WIDTH   : serialized word width (fixed at 16)
//   SEL_W   : width of the bit-select index (log2 of WIDTH)
//   state_t : controller FSM states
// -----------------------------------------------------------------------------
package bit_ser_pkg;

   localparam int WIDTH = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : bit_ser_pkg

// File: rtl/bit_serializer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_ctrl_if
// Request / serial-stream bundle for bit_serializer_ctrl.
//   start, data_in, msb_first, nbits : transfer request and its parameters
//   abort                            : cancel of a transfer in progress
//   ser_ready                        : downstream accepts the current bit
//   sel, ser_out, ser_valid          : serial stream and its bit index
//   busy, done                       : transfer status
// Modports: master drives the request side, slave is the controller.
// -----------------------------------------------------------------------------
interface bit_serializer_ctrl_if;
   import bit_ser_pkg::*;

   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             msb_first;
   logic [SEL_W-1:0] nbits;
   logic             abort;
   logic             ser_ready;
   logic [SEL_W-1:0] sel;
   logic             ser_out;
   logic             ser_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, data_in, msb_first, nbits, abort, ser_ready,
      input  sel, ser_out, ser_valid, busy, done
   );

   modport slave (
      input  start, data_in, msb_first, nbits, abort, ser_ready,
      output sel, ser_out, ser_valid, busy, done
   );

endinterface : bit_serializer_ctrl_if

// File: rtl/bit_serializer_ctrl_mux.sv
// -----------------------------------------------------------------------------
// mux16to1
// Plain 16:1 bit-select multiplexer.
//   data : 16-bit input word
//   sel  : index of the bit to pass through
//   y    : data[sel]
// -----------------------------------------------------------------------------
module mux16to1
   import bit_ser_pkg::*;
(
   input  logic [WIDTH-1:0] data,
   input  logic [SEL_W-1:0] sel,
   output logic             y
);

   assign y = data[sel];

endmodule : mux16to1

// File: rtl/bit_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serializer_ctrl
// Captures a 16-bit word on start and streams 1..16 of its bits, LSB-first or
// MSB-first, over a valid/ready handshake. Supports abort and backpressure.
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous active-high reset
//   bus : bit_serializer_ctrl_if.slave (request, serial stream, status)
// -----------------------------------------------------------------------------
module bit_serializer_ctrl
   import bit_ser_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   bit_serializer_ctrl_if.slave        bus
);

   state_t           state;
   logic [WIDTH-1:0] word;
   logic             msb_mode;
   logic [SEL_W-1:0] last_idx;
   logic [SEL_W-1:0] count;
   logic [SEL_W-1:0] sel;
   logic             ser_valid;
   logic             busy;
   logic             done;
   logic             mux_bit;

   // Bit select is driven only by registered word and sel, so there is no
   // combinational path from ser_ready to the stream.
   mux16to1 u_mux (
      .data (word),
      .sel  (sel),
      .y    (mux_bit)
   );

   // NOTE: every register below is assigned with <= so all of them update
   // together from the pre-edge values; blocking assigns here would let later
   // statements see half-updated state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         word      <= '0;
         msb_mode  <= 1'b0;
         last_idx  <= '0;
         count     <= '0;
         sel       <= '0;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (bus.start && !bus.abort) begin
                  word      <= bus.data_in;
                  msb_mode  <= bus.msb_first;
                  last_idx  <= bus.nbits;
                  count     <= '0;
                  sel       <= bus.msb_first ? SEL_W'(WIDTH - 1) : '0;
                  ser_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               // Abort wins over a simultaneous handshake: that bit is dropped.
               if (bus.abort) begin
                  ser_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else if (bus.ser_ready) begin
                  if (count == last_idx) begin
                     ser_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     count <= count + 1'b1;
                     // 4-bit arithmetic gives the modulo-16 step for free.
                     sel   <= msb_mode ? sel - 1'b1 : sel + 1'b1;
                  end
               end
            end

            ST_DONE: begin
               // Single-cycle state; abort leads to the same place.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               ser_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.sel       = sel;
   assign bus.ser_out   = ser_valid & mux_bit;
   assign bus.ser_valid = ser_valid;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule : bit_serializer_ctrl
